// File: rtl/node_sequencer_if.sv
// Handshake bundle between a node sequencer and its controller/accumulator.
// Controller side (master) drives go, data_valid and done_ack; the sequencer
// (slave) drives accumulator controls, index and status.
interface node_sequencer_if #(
    parameter int CNT_W = 7
);
    logic             go;
    logic             data_valid;
    logic             done_ack;
    logic             reset_acc;
    logic             start;
    logic [CNT_W-1:0] cnt_val;
    logic             busy;
    logic             acc_done;
    logic             err_overrun;
    logic [15:0]      eval_count;

    modport master (
        output go, data_valid, done_ack,
        input  reset_acc, start, cnt_val, busy, acc_done, err_overrun, eval_count
    );

    modport slave (
        input  go, data_valid, done_ack,
        output reset_acc, start, cnt_val, busy, acc_done, err_overrun, eval_count
    );
endinterface

// File: rtl/node_sequencer.sv
// Sequences one accumulation of NUM_INPUTS coef/data pairs into a downstream node.
// Latency: go (idle) to acc_done is NUM_INPUTS+3 cycles with data_valid held high.
// Backpressure: data_valid low stalls the sweep indefinitely; DONE holds until done_ack.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries go/data_valid/done_ack
// in, and reset_acc/start/cnt_val/busy/acc_done/err_overrun/eval_count out.
module node_sequencer #(
    parameter int NUM_INPUTS = 64,
    parameter int CNT_W      = 7
) (
    input  logic              clk,
    input  logic              rst,
    node_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUTS - 1);

    state_t           state;
    logic [CNT_W-1:0] idx;
    logic             reset_acc_q;
    logic             busy_q;
    logic             acc_done_q;
    logic             err_q;
    logic [15:0]      eval_cnt;

    // Status outputs are registered alongside the state so they change only
    // on the edge that enters or leaves the corresponding state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            reset_acc_q <= 1'b0;
            busy_q      <= 1'b0;
            acc_done_q  <= 1'b0;
            err_q       <= 1'b0;
            eval_cnt    <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.go) begin
                        state       <= CLEAR;
                        reset_acc_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (bus.go) err_q <= 1'b1;
                    state       <= RUN;
                    reset_acc_q <= 1'b0;
                end
                RUN: begin
                    if (bus.go) err_q <= 1'b1;
                    if (bus.data_valid) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= DRAIN;
                        end else begin
                            idx <= idx + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // One idle cycle lets the last accumulate land before DONE.
                    if (bus.go) err_q <= 1'b1;
                    state      <= DONE;
                    busy_q     <= 1'b0;
                    acc_done_q <= 1'b1;
                    eval_cnt   <= eval_cnt + 16'd1;
                end
                DONE: begin
                    // go is only honoured together with done_ack; alone it is
                    // neither sequenced nor an overrun.
                    if (bus.done_ack) begin
                        acc_done_q <= 1'b0;
                        if (bus.go) begin
                            state       <= CLEAR;
                            reset_acc_q <= 1'b1;
                            busy_q      <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    idx         <= '0;
                    reset_acc_q <= 1'b0;
                    busy_q      <= 1'b0;
                    acc_done_q  <= 1'b0;
                end
            endcase
        end
    end

    // start is the only combinational output: the accumulator must see the
    // hold released in the same cycle the pair is valid.
    assign bus.start       = (state == RUN) ? ~bus.data_valid : 1'b1;
    assign bus.reset_acc   = reset_acc_q;
    assign bus.cnt_val     = idx;
    assign bus.busy        = busy_q;
    assign bus.acc_done    = acc_done_q;
    assign bus.err_overrun = err_q;
    assign bus.eval_count  = eval_cnt;

endmodule

// File: tb/tb_node_sequencer.sv
module tb_node_sequencer;

    localparam int N  = 64;
    localparam int CW = 7;

    logic clk = 1'b0;
    logic rst;
    logic rst2;

    node_sequencer_if #(.CNT_W(CW)) bus ();
    node_sequencer_if #(.CNT_W(1))  bus2 ();

    node_sequencer #(.NUM_INPUTS(N), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    node_sequencer #(.NUM_INPUTS(2), .CNT_W(1)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an evaluation is "t cycles since it began" plus the
    // number of valid beats consumed; t=0 is the clear cycle, beats==N means
    // the drain cycle, m_done covers the wait for acknowledge.
    int          m_t     = -1;
    int          m_beats = 0;
    bit          m_done  = 1'b0;
    bit          m_err   = 1'b0;
    logic [15:0] m_evals = 16'd0;

    function automatic logic [27:0] exp_vec(input logic dv);
        logic          clr;
        logic          run;
        logic          drn;
        logic [CW-1:0] ix;
        clr = (m_t == 0);
        run = (m_t > 0) && (m_beats < N);
        drn = (m_t > 0) && (m_beats == N);
        ix  = run ? CW'(m_beats) : '0;
        return {clr, run ? ~dv : 1'b1, clr | run | drn, logic'(m_done), logic'(m_err), m_evals, ix};
    endfunction

    function automatic logic [27:0] obs_vec();
        return {bus.reset_acc, bus.start, bus.busy, bus.acc_done, bus.err_overrun,
                bus.eval_count, bus.cnt_val};
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_t = -1; m_beats = 0; m_done = 1'b0; m_err = 1'b0; m_evals = 16'd0;
        end else if (m_done) begin
            if (bus.done_ack) begin
                m_done = 1'b0;
                if (bus.go) begin m_t = 0; m_beats = 0; end
            end
        end else if (m_t < 0) begin
            if (bus.go) begin m_t = 0; m_beats = 0; end
        end else begin
            if (bus.go) m_err = 1'b1;
            if (m_beats == N) begin
                m_done  = 1'b1;
                m_t     = -1;
                m_evals = m_evals + 16'd1;
            end else begin
                if (m_t > 0 && bus.data_valid) m_beats++;
                m_t++;
            end
        end
    endtask

    task automatic drive(input bit go, input bit dv, input bit ack, input bit r);
        bus.go = go; bus.data_valid = dv; bus.done_ack = ack; rst = r;
        #1;
    endtask

    task automatic tick();
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [27:0] idle_v;
        idle_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 7'h00};
        drive(0, 0, 0, 1); tick();
        drive(0, 0, 0, 0);
        n_checks++;
        if (obs_vec() !== idle_v) begin
            n_fail++; $display("FAIL reset_state: got %h expected %h", obs_vec(), idle_v);
        end
        // reset must win over go/data_valid/done_ack
        drive(1, 1, 1, 1); tick();
        drive(0, 0, 0, 0);
        n_checks++;
        if (obs_vec() !== idle_v) begin
            n_fail++; $display("FAIL reset_priority: got %h expected %h", obs_vec(), idle_v);
        end
        tick();
    endtask

    task automatic test_basic();
        int  ra_cnt = 0, st0_cnt = 0, done_at = -1;
        bit  seq_ok = 1'b1;
        drive(0, 0, 0, 1); tick();
        for (int k = 0; k < 200 && done_at < 0; k++) begin
            drive(k == 0, 1, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec(bus.data_valid)) begin
                n_fail++; $display("FAIL basic k=%0d: got %h expected %h", k, obs_vec(), exp_vec(bus.data_valid));
            end
            if (bus.reset_acc) ra_cnt++;
            if (!bus.start) begin
                if (bus.cnt_val !== CW'(st0_cnt)) seq_ok = 1'b0;
                st0_cnt++;
            end
            if (bus.acc_done) done_at = k;
            tick();
        end
        n_checks++;
        if (done_at != 67) begin n_fail++; $display("FAIL basic_latency: got %0d expected 67", done_at); end
        n_checks++;
        if (ra_cnt != 1) begin n_fail++; $display("FAIL basic_reset_acc_cycles: got %0d expected 1", ra_cnt); end
        n_checks++;
        if (st0_cnt != 64) begin n_fail++; $display("FAIL basic_start_low_cycles: got %0d expected 64", st0_cnt); end
        n_checks++;
        if (!seq_ok) begin n_fail++; $display("FAIL basic_cnt_sequence: got out-of-order index expected 0..63"); end
        n_checks++;
        if (bus.eval_count !== 16'd1) begin n_fail++; $display("FAIL basic_eval_count: got %0d expected 1", bus.eval_count); end
        drive(0, 0, 1, 0); tick();
    endtask

    task automatic test_stall();
        int stall_left = 5, done_at = -1, bad_stall = 0;
        bit dv;
        for (int k = 0; k < 300 && done_at < 0; k++) begin
            dv = 1'b1;
            if (m_t > 0 && m_beats == 10 && stall_left > 0) dv = 1'b0;
            drive(k == 0, dv, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec(bus.data_valid)) begin
                n_fail++; $display("FAIL stall k=%0d: got %h expected %h", k, obs_vec(), exp_vec(bus.data_valid));
            end
            if (!dv) begin
                if (bus.cnt_val !== CW'(10) || bus.start !== 1'b1) bad_stall++;
                stall_left--;
            end
            if (bus.acc_done) done_at = k;
            tick();
        end
        n_checks++;
        if (bad_stall != 0 || stall_left != 0) begin
            n_fail++; $display("FAIL stall_hold: got %0d bad cycles, %0d unused expected 0, 0", bad_stall, stall_left);
        end
        n_checks++;
        if (done_at != 72) begin n_fail++; $display("FAIL stall_latency: got %0d expected 72", done_at); end
        drive(0, 0, 1, 0); tick();
    endtask

    task automatic test_overrun();
        int done_at = -1;
        bit sent = 1'b0, g;
        for (int k = 0; k < 200 && done_at < 0; k++) begin
            g = (k == 0) || (m_t > 0 && m_beats == 20 && !sent);
            if (k != 0 && g) sent = 1'b1;
            drive(g, 1, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec(bus.data_valid)) begin
                n_fail++; $display("FAIL overrun k=%0d: got %h expected %h", k, obs_vec(), exp_vec(bus.data_valid));
            end
            if (bus.acc_done) done_at = k;
            tick();
        end
        n_checks++;
        if (done_at != 67) begin n_fail++; $display("FAIL overrun_latency: got %0d expected 67", done_at); end
        drive(0, 0, 1, 0); tick();
        drive(0, 0, 0, 0);
        n_checks++;
        if (bus.err_overrun !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL overrun_sticky: got err=%b busy=%b expected err=1 busy=0", bus.err_overrun, bus.busy);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int done_at = -1;
        drive(0, 0, 0, 1); tick();
        for (int k = 0; k < 200 && done_at < 0; k++) begin
            drive(k == 0, 1, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec(bus.data_valid)) begin
                n_fail++; $display("FAIL b2b_first k=%0d: got %h expected %h", k, obs_vec(), exp_vec(bus.data_valid));
            end
            if (bus.acc_done) done_at = k;
            tick();
        end
        // go without ack in DONE: ignored, no overrun
        drive(1, 0, 0, 0); tick();
        drive(1, 0, 1, 0);
        n_checks++;
        if (bus.err_overrun !== 1'b0 || bus.acc_done !== 1'b1) begin
            n_fail++; $display("FAIL done_go_ignored: got err=%b done=%b expected err=0 done=1", bus.err_overrun, bus.acc_done);
        end
        tick();
        drive(0, 1, 0, 0);
        n_checks++;
        if (bus.reset_acc !== 1'b1 || bus.busy !== 1'b1 || bus.acc_done !== 1'b0) begin
            n_fail++; $display("FAIL b2b_clear: got reset_acc=%b busy=%b done=%b expected 1 1 0", bus.reset_acc, bus.busy, bus.acc_done);
        end
        done_at = -1;
        for (int k = 0; k < 200 && done_at < 0; k++) begin
            drive(0, 1, 0, 0);
            n_checks++;
            if (obs_vec() !== exp_vec(bus.data_valid)) begin
                n_fail++; $display("FAIL b2b_second k=%0d: got %h expected %h", k, obs_vec(), exp_vec(bus.data_valid));
            end
            if (bus.acc_done) done_at = k;
            tick();
        end
        n_checks++;
        if (bus.eval_count !== 16'd2) begin n_fail++; $display("FAIL b2b_eval_count: got %0d expected 2", bus.eval_count); end
        drive(0, 0, 1, 0); tick();
    endtask

    task automatic test_reset_mid_run();
        int done_seen = 0;
        for (int k = 0; k < 200 && !(m_t > 0 && m_beats == 40); k++) begin
            drive(k == 0, 1, 0, 0);
            tick();
        end
        drive(0, 1, 0, 1); tick();
        drive(0, 1, 0, 0);
        n_checks++;
        if (bus.cnt_val !== CW'(0) || bus.busy !== 1'b0 || bus.eval_count !== 16'd0 || bus.acc_done !== 1'b0) begin
            n_fail++; $display("FAIL mid_run_reset: got cnt=%0d busy=%b evals=%0d done=%b expected 0 0 0 0",
                               bus.cnt_val, bus.busy, bus.eval_count, bus.acc_done);
        end
        for (int k = 0; k < 80; k++) begin
            drive(0, 1, 0, 0);
            if (bus.acc_done) done_seen++;
            tick();
        end
        n_checks++;
        if (done_seen != 0) begin n_fail++; $display("FAIL mid_run_no_done: got %0d done cycles expected 0", done_seen); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom % 8) == 0, ($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 500) == 0);
            n_checks++;
            if (obs_vec() !== exp_vec(bus.data_valid)) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL random k=%0d: got %h expected %h", k, obs_vec(), exp_vec(bus.data_valid));
            end
            tick();
        end
        drive(0, 0, 0, 1); tick();
    endtask

    // Two-input instance cycled continuously with go/data_valid/done_ack high.
    task automatic test_wrap();
        int seen = 0, cyc = 0;
        bus2.go = 1'b1; bus2.data_valid = 1'b1; bus2.done_ack = 1'b1;
        rst2 = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        while (seen < 65535 && cyc < 400000) begin
            @(negedge clk); cyc++;
            if (bus2.acc_done) seen++;
        end
        n_checks++;
        if (bus2.eval_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: got %h expected ffff", bus2.eval_count); end
        while (seen < 65536 && cyc < 400000) begin
            @(negedge clk); cyc++;
            if (bus2.acc_done) seen++;
        end
        n_checks++;
        if (bus2.eval_count !== 16'h0000 || seen != 65536) begin
            n_fail++; $display("FAIL wrap_to_zero: got %h after %0d completions expected 0000 after 65536", bus2.eval_count, seen);
        end
        bus2.go = 1'b0; bus2.done_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rst2 = 1'b1;
        bus.go = 1'b0; bus.data_valid = 1'b0; bus.done_ack = 1'b0;
        bus2.go = 1'b0; bus2.data_valid = 1'b0; bus2.done_ack = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_overrun();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
